// File: rtl/mpsoc_sysid_checker_if.sv
// ---------------------------------------------------------------------------
// mpsoc_sysid_checker_if
//   Avalon-MM read-only link between the system-ID checker (master) and the
//   control_slave port of the system-ID peripheral (slave).
//
//   address        master -> slave  word address (0 = system ID, 1 = timestamp)
//   read           master -> slave  read request
//   waitrequest    slave -> master  stall; master holds address/read while high
//   readdata       slave -> master  32-bit read data
//   readdatavalid  slave -> master  readdata qualifier
// ---------------------------------------------------------------------------
interface mpsoc_sysid_checker_if;
   logic        address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address,
      output read,
      input  waitrequest,
      input  readdata,
      input  readdatavalid
   );

   modport slave (
      input  address,
      input  read,
      output waitrequest,
      output readdata,
      output readdatavalid
   );
endinterface

// File: rtl/mpsoc_sysid_checker.sv
// ---------------------------------------------------------------------------
// mpsoc_sysid_checker
//   Avalon-MM read master that, on a start pulse, reads the system ID (word 0)
//   and then the build timestamp (word 1) from the sysid peripheral, compares
//   both against the values built into the image and reports the result.
//   Each access is bounded by TIMEOUT_CYCLES; a stuck access ends the check
//   with timeout=1 and pass=0.
//
//   Optional feature macro: SYSID_CHECK_RETRY_EN
//     defined   - a failing check restarts at the ID read, up to MAX_RETRIES
//                 extra passes per start; flags reflect the final attempt.
//     undefined - single attempt per start; MAX_RETRIES has no effect.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   1-cycle pulse, begins a check when idle/done
//   avm          if   Avalon-MM master modport (address/read/waitrequest/
//                     readdata/readdatavalid)
//   busy         out  check in progress
//   done         out  result valid, sticky until next start or reset
//   pass         out  id_ok & ts_ok & !timeout (valid while done)
//   id_ok        out  captured ID matched EXPECTED_ID
//   ts_ok        out  captured timestamp matched EXPECTED_TS
//   timeout      out  an access exceeded TIMEOUT_CYCLES
//   captured_id  out  last ID read
//   captured_ts  out  last timestamp read
// ---------------------------------------------------------------------------
module mpsoc_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h624E_5E3A,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   mpsoc_sysid_checker_if.master       avm,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        id_ok,
   output logic                        ts_ok,
   output logic                        timeout,
   output logic [31:0]                 captured_id,
   output logic [31:0]                 captured_ts
);

   // Timeout counter is at least 8 bits wide, wider if the limit needs it.
   localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam int unsigned RW = ($clog2(MAX_RETRIES + 1) > 1) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

`ifdef SYSID_CHECK_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WT_ID,
      ST_RD_TS,
      ST_WT_TS,
      ST_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic            read_q, read_d;
   logic            address_q, address_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            id_ok_q, id_ok_d;
   logic            ts_ok_q, ts_ok_d;
   logic            timeout_q, timeout_d;
   logic [31:0]     captured_id_q, captured_id_d;
   logic [31:0]     captured_ts_q, captured_ts_d;

   // End-of-attempt request raised by the state logic, resolved afterwards
   // into DONE or a restart so both end paths (compare, timeout) share it.
   logic            fin;
   logic            fin_ok;
   logic            can_retry;

   assign can_retry = RETRY_EN && (retry_q < RETRY_MAX);

   always_comb begin
      state_d       = state_q;
      tmo_cnt_d     = tmo_cnt_q;
      retry_d       = retry_q;
      read_d        = read_q;
      address_d     = address_q;
      busy_d        = busy_q;
      done_d        = done_q;
      pass_d        = pass_q;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      timeout_d     = timeout_q;
      captured_id_d = captured_id_q;
      captured_ts_d = captured_ts_q;
      fin           = 1'b0;
      fin_ok        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Late readdatavalid is ignored here by construction.
            if (start) begin
               state_d   = ST_RD_ID;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
               retry_d   = '0;
               read_d    = 1'b1;
               address_d = 1'b0;
               tmo_cnt_d = '0;
            end
         end

         ST_RD_ID, ST_WT_ID: begin
            // In RD_ID, data only counts if the read is accepted that cycle.
            if (avm.readdatavalid && (state_q == ST_WT_ID || !avm.waitrequest)) begin
               captured_id_d = avm.readdata;
               id_ok_d       = (avm.readdata == EXPECTED_ID);
               state_d       = ST_RD_TS;
               read_d        = 1'b1;
               address_d     = 1'b1;
               tmo_cnt_d     = '0;
            end else if (tmo_cnt_q == TO_LIMIT) begin
               timeout_d = 1'b1;
               read_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               fin       = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (state_q == ST_RD_ID && !avm.waitrequest) begin
                  state_d = ST_WT_ID;
                  read_d  = 1'b0;
               end
            end
         end

         ST_RD_TS, ST_WT_TS: begin
            if (avm.readdatavalid && (state_q == ST_WT_TS || !avm.waitrequest)) begin
               captured_ts_d = avm.readdata;
               ts_ok_d       = (avm.readdata == EXPECTED_TS);
               read_d        = 1'b0;
               fin           = 1'b1;
               fin_ok        = id_ok_q && (avm.readdata == EXPECTED_TS);
            end else if (tmo_cnt_q == TO_LIMIT) begin
               timeout_d = 1'b1;
               read_d    = 1'b0;
               ts_ok_d   = 1'b0;
               fin       = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (state_q == ST_RD_TS && !avm.waitrequest) begin
                  state_d = ST_WT_TS;
                  read_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            read_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      if (fin) begin
         if (fin_ok) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
         end else if (can_retry) begin
            // Restart the whole check; flags are rebuilt by the new attempt.
            retry_d   = retry_q + 1'b1;
            state_d   = ST_RD_ID;
            read_d    = 1'b1;
            address_d = 1'b0;
            tmo_cnt_d = '0;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            timeout_d = 1'b0;
         end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            read_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tmo_cnt_q     <= '0;
         retry_q       <= '0;
         read_q        <= 1'b0;
         address_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         captured_id_q <= '0;
         captured_ts_q <= '0;
      end else begin
         state_q       <= state_d;
         tmo_cnt_q     <= tmo_cnt_d;
         retry_q       <= retry_d;
         read_q        <= read_d;
         address_q     <= address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         captured_id_q <= captured_id_d;
         captured_ts_q <= captured_ts_d;
      end
   end

   assign avm.read    = read_q;
   assign avm.address = address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign captured_id = captured_id_q;
   assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_mpsoc_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_sysid_checker
//   Directed bench for mpsoc_sysid_checker with a small sysid slave model
//   (programmable stall, latency, dropped ID response, corrupted TS words).
//   Build with +define+SYSID_CHECK_RETRY_EN to exercise the retry path.
// ---------------------------------------------------------------------------
module tb_mpsoc_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h624E_5E3A;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] captured_id, captured_ts;

   always #5 clock = ~clock;

   mpsoc_sysid_checker_if avm_if ();

   mpsoc_sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(255),
      .MAX_RETRIES   (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .avm        (avm_if),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .id_ok      (id_ok),
      .ts_ok      (ts_ok),
      .timeout    (timeout),
      .captured_id(captured_id),
      .captured_ts(captured_ts)
   );

   // ---------------- slave model ----------------
   int unsigned cfg_wait    = 0;
   int unsigned cfg_lat     = 1;
   bit          cfg_lat0    = 1'b0;
   bit          cfg_drop_id = 1'b0;
   logic [31:0] cfg_id      = EXP_ID;
   logic [31:0] cfg_ts      = EXP_TS;
   int unsigned cfg_ts_bad  = 0;
   int unsigned ts_base     = 0;

   int unsigned ts_reads    = 0;
   int unsigned stall_viol  = 0;
   int unsigned outst_viol  = 0;
   int unsigned stall_cnt   = 0;
   int unsigned pend        = 0;
   logic        sl_rdv      = 1'b0;
   logic [31:0] sl_data     = '0;
   logic [31:0] pdata       = '0;

   assign avm_if.waitrequest   = avm_if.read && (stall_cnt < cfg_wait);
   assign avm_if.readdatavalid = sl_rdv | (cfg_lat0 && avm_if.read && !avm_if.waitrequest);
   assign avm_if.readdata      = cfg_lat0 ? (avm_if.address ? cfg_ts : cfg_id) : sl_data;

   always @(posedge clock) begin
      logic rd, wr, adr, acc, rs;
      rd  = avm_if.read;
      wr  = avm_if.waitrequest;
      adr = avm_if.address;
      rs  = reset;
      acc = rd && !wr;
      if (rd && pend != 0) outst_viol++;
      #1;
      if (rd && wr && !rs && (!avm_if.read || avm_if.address != adr)) stall_viol++;
      sl_rdv = 1'b0;
      if (acc && adr) ts_reads++;
      if (acc && !cfg_lat0 && !(cfg_drop_id && !adr)) begin
         pend  = cfg_lat;
         if (!adr)                            pdata = cfg_id;
         else if (ts_reads - ts_base <= cfg_ts_bad) pdata = 32'h0;
         else                                 pdata = cfg_ts;
      end
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            sl_rdv  = 1'b1;
            sl_data = pdata;
         end
      end
      if (acc || !rd) stall_cnt = 0;
      else if (wr)    stall_cnt++;
   end

   // ---------------- checking ----------------
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Counts rising edges after the start edge until done is seen.
   task automatic wait_done(input int unsigned limit, output int unsigned edges);
      edges = 0;
      while (!done && edges < limit) begin
         @(posedge clock);
         #1;
         edges++;
      end
   endtask

   // {pass, id_ok, ts_ok, timeout}
   function automatic logic [31:0] flags();
      return {28'h0, pass, id_ok, ts_ok, timeout};
   endfunction

   function automatic logic [31:0] ctrl();
      return {24'h0, busy, done, pass, id_ok, ts_ok, timeout, avm_if.read, avm_if.address};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned lat;
      int unsigned base;
      int unsigned guard;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state
      chk("reset_ctrl", ctrl(), 32'h0);
      chk("reset_cid", captured_id, 32'h0);
      chk("reset_cts", captured_ts, 32'h0);

      // 1: nominal, zero wait, 1-cycle latency
      pulse_start();
      chk("t1_read_after_start", {29'h0, busy, avm_if.read, avm_if.address}, 32'h6);
      wait_done(50, lat);
      chk("t1_latency", lat, 4);
      chk("t1_flags", flags(), 32'hE);
      chk("t1_cts", captured_ts, EXP_TS);
      chk("t1_busy_read", {30'h0, busy, avm_if.read}, 32'h0);

      // 2: wrong ID
      cfg_id = 32'h0000_0001;
      pulse_start();
      wait_done(50, lat);
      chk("t2_done", {31'h0, done}, 32'h1);
      chk("t2_flags", flags(), 32'h2);
      chk("t2_cid", captured_id, 32'h1);
      repeat (3) @(negedge clock);
      chk("t2_sticky", {31'h0, done}, 32'h1);

      // 3: 4-cycle stall per read, plus an ignored start while busy
      cfg_id   = EXP_ID;
      cfg_wait = 4;
      base     = ts_reads;
      pulse_start();
      pulse_start();
      wait_done(50, lat);
      chk("t3_latency_after_2nd_start", lat, 10);
      chk("t3_flags", flags(), 32'hE);
      chk("t3_stall_stable", stall_viol, 0);
      chk("t3_ts_reads", ts_reads - base, 1);

      // 4: ID response never arrives
      cfg_wait    = 0;
      cfg_drop_id = 1'b1;
      pulse_start();
      wait_done(400, lat);
      chk("t4_latency", lat, 256);
      chk("t4_flags", flags(), 32'h1);
      chk("t4_done_read", {30'h0, done, avm_if.read}, 32'h2);

      // 4b: zero-latency slave, data in the accept cycle
      cfg_drop_id = 1'b0;
      cfg_lat0    = 1'b1;
      pulse_start();
      wait_done(50, lat);
      chk("t4b_latency", lat, 2);
      chk("t4b_flags", flags(), 32'hE);

      // 5: reset while waiting for the timestamp
      cfg_lat0 = 1'b0;
      cfg_lat  = 5;
      pulse_start();
      guard = 0;
      while (!(avm_if.read && avm_if.address && !avm_if.waitrequest) && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      chk("t5_reached_ts", {31'h0, guard < 50}, 32'h1);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("t5_reset_ctrl", ctrl(), 32'h0);
      chk("t5_reset_cts", captured_ts, 32'h0);
      repeat (8) @(negedge clock);
      chk("t5_late_ignored", ctrl(), 32'h0);
      chk("t5_late_cts", captured_ts, 32'h0);
      cfg_lat = 1;
      pulse_start();
      wait_done(50, lat);
      chk("t5_restart_latency", lat, 4);
      chk("t5_restart_flags", flags(), 32'hE);

      // Reset and start together: reset wins
      @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      chk("rst_start_ctrl", ctrl(), 32'h0);

      // 6: timestamp mismatch
`ifdef SYSID_CHECK_RETRY_EN
      ts_base    = ts_reads;
      cfg_ts_bad = 1;
      pulse_start();
      wait_done(100, lat);
      chk("t6_retry_ts_reads", ts_reads - ts_base, 2);
      chk("t6_retry_flags", flags(), 32'hE);
      chk("t6_retry_cts", captured_ts, EXP_TS);
      ts_base    = ts_reads;
      cfg_ts_bad = 100;
      pulse_start();
      wait_done(100, lat);
      chk("t6_exhaust_ts_reads", ts_reads - ts_base, 4);
      chk("t6_exhaust_flags", flags(), 32'h4);
      chk("t6_exhaust_done", {31'h0, done}, 32'h1);
`else
      ts_base    = ts_reads;
      cfg_ts_bad = 1;
      pulse_start();
      wait_done(100, lat);
      chk("t6_single_ts_reads", ts_reads - ts_base, 1);
      chk("t6_single_flags", flags(), 32'h4);
      chk("t6_single_cts", captured_ts, 32'h0);
      chk("t6_single_latency", lat, 4);
`endif
      chk("outstanding_reads", outst_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
